snes_pad_responder: RTL
=======================

Name: snes_pad_responder

Overview:
Controller-side end of the SNES pad serial protocol. It emulates a pad on the latch/pulse/data wires so the existing SNES controller reader, or an external console, can be driven from on-chip button state.
- Typical uses: loopback test of the reader, and replaying scripted input.
- Takes a 16-bit active-high button word.
- Presents it as an active-low serial stream, one bit per rising edge of pulse.

Parameters:
SYNC_STAGES, 2, flip-flop stages on the latch and pulse inputs (minimum 2).
NUM_BITS, 16, bits per frame before the data line parks low.

Ports:
clk  in  1  system clock
rst_btn  in  1  asynchronous active-low reset
buttons  in  16  active-high button state; bit 0 (B) is shifted first, bit 15 last
latch  in  1  host latch, asynchronous to clk
pulse  in  1  host shift clock, asynchronous to clk
data  out  1  serial data, active-low (0 = pressed)
busy  out  1  high from latch rise until frame complete
bit_count  out  5  number of pulse rising edges accepted in the current frame
frame_done  out  1  one-cycle strobe when the NUM_BITS-th bit has been shifted

Behaviour:
- Interface: one clock (clk); reset rst_btn is asynchronous and active-low.
- Reset values: data=1, busy=0, bit_count=0, frame_done=0, shift register=0, state=IDLE.
- Input conditioning:
  - latch and pulse each pass through a SYNC_STAGES flop chain.
  - Rise/fall detection compares the last synchronized stage against one further flop.
  - All pin-to-data latency is SYNC_STAGES+1 clk cycles.
- States: IDLE, LOAD, SHIFT, PARK.
- IDLE:
  - data=1, busy=0.
  - latch rise -> LOAD.
- LOAD:
  - Occupies the latch-high window.
  - Shift register reloads from buttons every cycle while latch stays high, so the last value before latch fall is sent.
  - bit_count=0, busy=1, data=~buttons[0] (tracks live).
  - latch fall -> SHIFT.
- SHIFT:
  - data=~shreg[0].
  - On each pulse rise: shreg shifts right with 1 filled at MSB, bit_count+1.
  - When bit_count reaches NUM_BITS -> PARK, frame_done=1 for exactly one cycle.
- PARK:
  - data=0 constant; further pulse rises are ignored and bit_count saturates at NUM_BITS.
  - busy=0.
  - latch rise -> LOAD.
- Pulse rises seen in LOAD or IDLE are ignored.
- latch rise in any state, including mid-SHIFT, aborts the frame and enters LOAD.
  - No frame_done is issued for the aborted frame.
- A latch rise and a pulse rise detected in the same cycle: latch wins, and the pulse is dropped.
- buttons changes during SHIFT do not affect the frame in progress.
- Reset asserted mid-frame returns all outputs to reset values immediately. This is asynchronous and does not wait for clk.

Optional Feature:
Macro SNES_PAD_TURBO_EN.
- Defined:
  - Adds input turbo_mask[15:0] and an internal frame-parity flop (reset 0) that toggles on every latch rise.
  - The value loaded in LOAD is buttons & ~(turbo_mask & {16{parity}}): masked buttons read as released on odd frames.
- Not defined:
  - No turbo_mask port and no parity flop.
  - The load value is buttons unchanged.

Test Plan:
1. Reset with latch=0, pulse=0 -> data=1, busy=0, bit_count=0. Release reset, idle 100 cycles -> unchanged.
2. buttons=16'h0001; latch high 12 cycles then low; 16 pulse rises spaced 20 cycles.
   - Required: data=0 before the first pulse, then 1 for bits 1-15.
   - After the 16th rise: data=0, frame_done high exactly 1 cycle, bit_count=16, busy=0.
3. buttons=16'hA5C3 frame -> sampled data after each pulse rise, inverted, reconstructs 16'hA5C3 LSB first. A 17th and 18th pulse leave data=0 and bit_count=16.
4. Start a frame with buttons=16'hFFFF, then latch rise after 5 pulses with buttons=16'h0000.
   - Required: busy stays 1, bit_count returns to 0, no frame_done.
   - New frame streams all 1s.
5. Drive a latch rise and a pulse rise on the same clk edge (post-sync) -> state LOAD, bit_count=0, pulse not counted.
   - Separately: change buttons 16'h0000->16'h0004 one cycle before latch fall -> bit 2 is sent as 0.
6. With SNES_PAD_TURBO_EN, buttons=16'h0003, turbo_mask=16'h0002, three consecutive frames -> decoded words 16'h0001, 16'h0003, 16'h0001.
   - Without the macro -> 16'h0003 every frame.

Source files
------------

// File: rtl/snes_pad_responder_if.sv
// Pad-side bus of the SNES pad responder: host wires, button word and frame status.
// turbo_mask exists only when SNES_PAD_TURBO_EN is defined.
interface snes_pad_responder_if;
    logic [15:0] buttons;
    logic        latch;
    logic        pulse;
    logic        data;
    logic        busy;
    logic [4:0]  bit_count;
    logic        frame_done;
`ifdef SNES_PAD_TURBO_EN
    logic [15:0] turbo_mask;

    modport master (
        output buttons, latch, pulse, turbo_mask,
        input  data, busy, bit_count, frame_done
    );
    modport slave (
        input  buttons, latch, pulse, turbo_mask,
        output data, busy, bit_count, frame_done
    );
`else
    modport master (
        output buttons, latch, pulse,
        input  data, busy, bit_count, frame_done
    );
    modport slave (
        input  buttons, latch, pulse,
        output data, busy, bit_count, frame_done
    );
`endif
endinterface

// File: rtl/snes_pad_responder.sv
// Emulates an SNES pad: serialises a 16-bit active-high button word as active-low data on pulse rises.
// Optional turbo masking on alternate frames when SNES_PAD_TURBO_EN is defined.
module snes_pad_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst_btn,
    snes_pad_responder_if.slave  pad
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PARK} state_t;

    localparam logic [4:0] LAST_BIT = 5'(NUM_BITS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] pulse_sync;
    logic                   latch_d;
    logic                   pulse_d;
    logic                   latch_rise;
    logic                   latch_fall;
    logic                   pulse_rise;
    logic                   shift_take;
    logic [15:0]            load_val;
    logic [15:0]            shreg;
    logic [4:0]             count;
    logic                   done;
    logic                   data_out;
    logic                   busy_out;

    // Input conditioning: synchroniser chains plus one edge-detect flop
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            latch_sync <= '0;
            pulse_sync <= '0;
            latch_d    <= 1'b0;
            pulse_d    <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], pad.latch};
            pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], pad.pulse};
            latch_d    <= latch_sync[SYNC_STAGES-1];
            pulse_d    <= pulse_sync[SYNC_STAGES-1];
        end
    end

    assign latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_d;
    assign latch_fall = ~latch_sync[SYNC_STAGES-1] & latch_d;
    assign pulse_rise = pulse_sync[SYNC_STAGES-1] & ~pulse_d;

`ifdef SNES_PAD_TURBO_EN
    logic parity;
    logic parity_next;

    // Parity flips on the latch rise itself, so the frame being loaded already sees its new parity
    assign parity_next = parity ^ latch_rise;
    assign load_val    = pad.buttons & ~(pad.turbo_mask & {16{parity_next}});

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) parity <= 1'b0;
        else          parity <= parity_next;
    end
`else
    assign load_val = pad.buttons;
`endif

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) state <= IDLE;
        else          state <= state_next;
    end

    // A latch rise overrides everything, including a same-cycle pulse rise
    always_comb begin
        state_next = state;
        if (latch_rise) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (latch_fall) state_next = SHIFT;
                SHIFT:   if (pulse_rise && count == LAST_BIT) state_next = PARK;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        data_out = 1'b1;
        busy_out = 1'b0;
        case (state)
            IDLE:  begin data_out = 1'b1;         busy_out = 1'b0; end
            LOAD:  begin data_out = ~load_val[0]; busy_out = 1'b1; end
            SHIFT: begin data_out = ~shreg[0];    busy_out = 1'b1; end
            PARK:  begin data_out = 1'b0;         busy_out = 1'b0; end
            default: begin data_out = 1'b1;       busy_out = 1'b0; end
        endcase
    end

    assign shift_take = (state == SHIFT) && pulse_rise && !latch_rise;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            shreg <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_next == LOAD) begin
                shreg <= load_val;
                count <= '0;
            end else if (shift_take) begin
                shreg <= {1'b1, shreg[15:1]};
                count <= count + 5'd1;
                if (count == LAST_BIT) done <= 1'b1;
            end
        end
    end

    assign pad.data       = data_out;
    assign pad.busy       = busy_out;
    assign pad.bit_count  = count;
    assign pad.frame_done = done;
endmodule
